mem_burst_arbiter: RTL and testbench
====================================

Name: mem_burst_arbiter

Overview:
- Shares the single mem_ctrl burst port (rd/wr burst handshake, MEM_DATA_BITS wide) between CH_NUM video channels, each with its own read and write burst master, e.g. video_pro frame writer/reader instances.
- Grants one burst at a time using round-robin over 2*CH_NUM request slots.
- Latches length and address for the granted burst, routes the data-path handshakes to the winner, and returns the finish pulse.
- Sits between the per-channel video_pro instances and mem_ctrl in the phy_clk domain.

Parameters:
- CH_NUM, 2, number of channels; legal range 1..4.
- MEM_DATA_BITS, 64, burst data width.
- ADDR_BITS, 24, burst address width.
- LEN_BITS, 10, burst length width.

Ports:
- clk  in  1  mem_ctrl phy_clk; all logic in this single domain.
- rst  in  1  asynchronous, active-high reset.
- ch_wr_burst_req  in  CH_NUM  per-channel write request.
- ch_wr_burst_len  in  CH_NUM*LEN_BITS  per-channel write length in words; channel c is slice [c*LEN_BITS +: LEN_BITS].
- ch_wr_burst_addr  in  CH_NUM*ADDR_BITS  per-channel write address.
- ch_wr_burst_data  in  CH_NUM*MEM_DATA_BITS  per-channel write data.
- ch_wr_burst_data_req  out  CH_NUM  write data request, granted channel only.
- ch_wr_burst_finish  out  CH_NUM  write finish pulse.
- ch_rd_burst_req  in  CH_NUM  per-channel read request.
- ch_rd_burst_len  in  CH_NUM*LEN_BITS  per-channel read length.
- ch_rd_burst_addr  in  CH_NUM*ADDR_BITS  per-channel read address.
- ch_rd_burst_data_valid  out  CH_NUM  read data valid, granted channel only.
- ch_rd_burst_data  out  MEM_DATA_BITS  read data, broadcast to all channels.
- ch_rd_burst_finish  out  CH_NUM  read finish pulse.
- wr_burst_req  out  1  to mem_ctrl.
- wr_burst_len  out  LEN_BITS  to mem_ctrl.
- wr_burst_addr  out  ADDR_BITS  to mem_ctrl.
- wr_burst_data_req  in  1  from mem_ctrl.
- wr_burst_data  out  MEM_DATA_BITS  to mem_ctrl.
- wr_burst_finish  in  1  from mem_ctrl.
- rd_burst_req  out  1  to mem_ctrl.
- rd_burst_len  out  LEN_BITS  to mem_ctrl.
- rd_burst_addr  out  ADDR_BITS  to mem_ctrl.
- rd_burst_data_valid  in  1  from mem_ctrl.
- rd_burst_data  in  MEM_DATA_BITS  from mem_ctrl.
- rd_burst_finish  in  1  from mem_ctrl.
- busy  out  1  high in any state other than IDLE.
- grant_slot  out  3  current or last granted slot.

Behaviour:
- Slot numbering: slot 2c = ch c write, slot 2c+1 = ch c read.
- Reset values, all asynchronous on rst:
  - State = IDLE.
  - Every registered output = 0.
  - Round-robin pointer last = 2*CH_NUM-1, so slot 0 has top priority after reset.
  - grant_slot = 0.
- States: IDLE, WR_BUSY, RD_BUSY, ZERO_FIN.
- IDLE:
  - Collects active slots (req bits).
  - Picks the first active slot searching last+1, last+2, ..., wrapping modulo 2*CH_NUM.
  - On the cycle a winner exists, registers grant_slot and last := winner, and latches the winner's len and addr.
  - If latched len == 0: go to ZERO_FIN.
  - Otherwise go to WR_BUSY or RD_BUSY. wr_burst_req or rd_burst_req goes high the next cycle, i.e. 1 cycle after the request is first seen.
- WR_BUSY:
  - wr_burst_req held at 1; len and addr held stable at the latched values.
  - wr_burst_data = data slice of the granted channel (combinational mux on registered grant).
  - ch_wr_burst_data_req[g] = wr_burst_data_req (combinational); all other bits 0.
  - On wr_burst_finish: ch_wr_burst_finish[g] = 1 in the same cycle (combinational), wr_burst_req registered to 0, state -> IDLE.
- RD_BUSY:
  - Symmetric to WR_BUSY. ch_rd_burst_data_valid[g] = rd_burst_data_valid; rd_burst_data is passed unregistered.
- ZERO_FIN:
  - No memory access is made.
  - Drives a 1-cycle registered finish pulse to the granted slot's finish bit, then -> IDLE.
- Arbitration gap: IDLE re-arbitrates on the cycle after finish.
- Requester contract: a requester must drop its req no later than the cycle after its finish. A req still high in that cycle is treated as a new request, but round-robin still favours other active slots.
- Unexpected handshakes:
  - A finish or data_valid from mem_ctrl while in IDLE, or one of the wrong kind (rd in WR_BUSY, wr in RD_BUSY), is ignored and not routed.
  - Non-granted channel outputs are always 0.
- Simultaneous requests are resolved solely by pointer order. No channel can be granted twice while another slot is continuously pending.
- Fairness: a deasserted req during IDLE simply loses that cycle; no request is stored.
- Reset mid-burst: all outputs drop to 0 immediately. No finish is issued to the interrupted requester, and mem_ctrl sees its req removed.

Test Plan:
- Single request: ch0 write, len=64, addr=0x000100 → wr_burst_req rises 1 cycle later with len 64 and addr 0x000100. 64 data_req beats are routed only to ch0. ch0 finish occurs in the same cycle as mem finish; busy=0 the next cycle.
- Contention: all 4 slots requesting continuously from reset → grant order 0,1,2,3,0,1 with no slot repeated out of order.
- Zero length: ch1 read, len=0 → no rd_burst_req. ch_rd_burst_finish[1] pulses 1 cycle after ZERO_FIN entry.
- Isolation: ch1 read granted while mem_ctrl asserts a stray wr_burst_finish → no channel finish; rd data_valid reaches only bit 1; ch0 outputs stay 0.
- Late release: ch0 holds req for 1 cycle after finish while ch1 is pending → ch1 is granted next.
- Reset mid-burst: assert rst during beat 10 of a 32-beat read → all outputs 0 asynchronously. After release, the first grant is slot 0 if it is requesting.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one mem_ctrl burst port between CH_NUM channels,
// each owning a write slot (2c) and a read slot (2c+1).
module mem_burst_arbiter #(
  parameter int unsigned CH_NUM        = 2,
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned LEN_BITS      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CH_NUM-1:0]               ch_wr_burst_req,
  input  logic [CH_NUM*LEN_BITS-1:0]      ch_wr_burst_len,
  input  logic [CH_NUM*ADDR_BITS-1:0]     ch_wr_burst_addr,
  input  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_burst_data,
  output logic [CH_NUM-1:0]               ch_wr_burst_data_req,
  output logic [CH_NUM-1:0]               ch_wr_burst_finish,
  input  logic [CH_NUM-1:0]               ch_rd_burst_req,
  input  logic [CH_NUM*LEN_BITS-1:0]      ch_rd_burst_len,
  input  logic [CH_NUM*ADDR_BITS-1:0]     ch_rd_burst_addr,
  output logic [CH_NUM-1:0]               ch_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]        ch_rd_burst_data,
  output logic [CH_NUM-1:0]               ch_rd_burst_finish,
  output logic                            wr_burst_req,
  output logic [LEN_BITS-1:0]             wr_burst_len,
  output logic [ADDR_BITS-1:0]            wr_burst_addr,
  input  logic                            wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
  input  logic                            wr_burst_finish,
  output logic                            rd_burst_req,
  output logic [LEN_BITS-1:0]             rd_burst_len,
  output logic [ADDR_BITS-1:0]            rd_burst_addr,
  input  logic                            rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]        rd_burst_data,
  input  logic                            rd_burst_finish,
  output logic                            busy,
  output logic [2:0]                      grant_slot
);

  localparam int unsigned Slots = 2 * CH_NUM;

  typedef enum logic [1:0] {StIdle, StWrBusy, StRdBusy, StZeroFin} state_e;

  state_e               state_q, state_d;
  logic [2:0]           last_q, grant_q, win_slot;
  logic                 win_found;
  logic [LEN_BITS-1:0]  len_q, win_len;
  logic [ADDR_BITS-1:0] addr_q, win_addr;
  logic                 wr_req_q, rd_req_q, zfin_q;
  logic [Slots-1:0]     req_vec;
  int unsigned          rr_idx;

  always_comb begin
    req_vec = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      req_vec[2*c]   = ch_wr_burst_req[c];
      req_vec[2*c+1] = ch_rd_burst_req[c];
    end
  end

  // Scan from farthest to nearest so the slot right after last_q wins.
  always_comb begin
    win_found = 1'b0;
    win_slot  = '0;
    rr_idx    = 0;
    for (int unsigned i = Slots; i >= 1; i--) begin
      rr_idx = (32'(last_q) + i) % Slots;
      if (req_vec[rr_idx]) begin
        win_found = 1'b1;
        win_slot  = rr_idx[2:0];
      end
    end
  end

  always_comb begin
    win_len  = '0;
    win_addr = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (32'(win_slot[2:1]) == c) begin
        if (win_slot[0]) begin
          win_len  = ch_rd_burst_len[c*LEN_BITS +: LEN_BITS];
          win_addr = ch_rd_burst_addr[c*ADDR_BITS +: ADDR_BITS];
        end else begin
          win_len  = ch_wr_burst_len[c*LEN_BITS +: LEN_BITS];
          win_addr = ch_wr_burst_addr[c*ADDR_BITS +: ADDR_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          if (win_len == '0)    state_d = StZeroFin;
          else if (win_slot[0]) state_d = StRdBusy;
          else                  state_d = StWrBusy;
        end
      end
      StWrBusy:  if (wr_burst_finish) state_d = StIdle;
      StRdBusy:  if (rd_burst_finish) state_d = StIdle;
      StZeroFin: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 3'(Slots - 1);
      grant_q  <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      zfin_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && win_found) begin
        grant_q <= win_slot;
        last_q  <= win_slot;
        len_q   <= win_len;
        addr_q  <= win_addr;
      end
      wr_req_q <= (state_d == StWrBusy);
      rd_req_q <= (state_d == StRdBusy);
      zfin_q   <= (state_q == StZeroFin);
    end
  end

  // Handshakes are routed only to the granted slot and only in the matching busy state.
  always_comb begin
    ch_wr_burst_data_req   = '0;
    ch_wr_burst_finish     = '0;
    ch_rd_burst_data_valid = '0;
    ch_rd_burst_finish     = '0;
    wr_burst_data          = '0;
    ch_rd_burst_data       = (state_q == StRdBusy) ? rd_burst_data : '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (32'(grant_q[2:1]) == c) begin
        if (state_q == StWrBusy && !grant_q[0]) begin
          ch_wr_burst_data_req[c] = wr_burst_data_req;
          ch_wr_burst_finish[c]   = wr_burst_finish;
          wr_burst_data           = ch_wr_burst_data[c*MEM_DATA_BITS +: MEM_DATA_BITS];
        end
        if (state_q == StRdBusy && grant_q[0]) begin
          ch_rd_burst_data_valid[c] = rd_burst_data_valid;
          ch_rd_burst_finish[c]     = rd_burst_finish;
        end
        if (zfin_q) begin
          if (grant_q[0]) ch_rd_burst_finish[c] = 1'b1;
          else            ch_wr_burst_finish[c] = 1'b1;
        end
      end
    end
    busy          = (state_q != StIdle);
    grant_slot    = grant_q;
    wr_burst_req  = wr_req_q;
    rd_burst_req  = rd_req_q;
    wr_burst_len  = len_q;
    rd_burst_len  = len_q;
    wr_burst_addr = addr_q;
    rd_burst_addr = addr_q;
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; expected grant order is queued as stimulus
// is applied and popped when the DUT reports a grant.
module tb_mem_burst_arbiter;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   ch_wr_burst_req, ch_wr_burst_data_req, ch_wr_burst_finish;
  logic [CH*LW-1:0] ch_wr_burst_len, ch_rd_burst_len;
  logic [CH*AW-1:0] ch_wr_burst_addr, ch_rd_burst_addr;
  logic [CH*DW-1:0] ch_wr_burst_data;
  logic [CH-1:0]   ch_rd_burst_req, ch_rd_burst_data_valid, ch_rd_burst_finish;
  logic [DW-1:0]   ch_rd_burst_data;
  logic            wr_burst_req, wr_burst_data_req, wr_burst_finish;
  logic [LW-1:0]   wr_burst_len, rd_burst_len;
  logic [AW-1:0]   wr_burst_addr, rd_burst_addr;
  logic [DW-1:0]   wr_burst_data, rd_burst_data;
  logic            rd_burst_req, rd_burst_data_valid, rd_burst_finish;
  logic            busy;
  logic [2:0]      grant_slot;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  mem_burst_arbiter #(
    .CH_NUM(CH), .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_wr_burst_req(ch_wr_burst_req), .ch_wr_burst_len(ch_wr_burst_len),
    .ch_wr_burst_addr(ch_wr_burst_addr), .ch_wr_burst_data(ch_wr_burst_data),
    .ch_wr_burst_data_req(ch_wr_burst_data_req), .ch_wr_burst_finish(ch_wr_burst_finish),
    .ch_rd_burst_req(ch_rd_burst_req), .ch_rd_burst_len(ch_rd_burst_len),
    .ch_rd_burst_addr(ch_rd_burst_addr), .ch_rd_burst_data_valid(ch_rd_burst_data_valid),
    .ch_rd_burst_data(ch_rd_burst_data), .ch_rd_burst_finish(ch_rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish),
    .busy(busy), .grant_slot(grant_slot)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed grant %0d expected none queued", tag, grant_slot);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(grant_slot), 64'(e));
    end
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd1);
  endtask

  task automatic clear_inputs();
    ch_wr_burst_req     = '0;
    ch_wr_burst_len     = '0;
    ch_wr_burst_addr    = '0;
    ch_wr_burst_data    = '0;
    ch_rd_burst_req     = '0;
    ch_rd_burst_len     = '0;
    ch_rd_burst_addr    = '0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = '0;
    rd_burst_finish     = 1'b0;
  endtask

  initial begin
    int beats;
    int e;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_slot), 64'd0);
    check("rst_wr_req", 64'(wr_burst_req), 64'd0);
    check("rst_rd_req", 64'(rd_burst_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write on ch0
    ch_wr_burst_req[0]       = 1'b1;
    ch_wr_burst_len[0+:LW]   = 10'd64;
    ch_wr_burst_addr[0+:AW]  = 24'h000100;
    ch_wr_burst_data[DW+:DW] = 64'h0000_0000_0000_00BB;
    exp_q.push_back(0);
    @(negedge clk);
    check("single_wr_req", 64'(wr_burst_req), 64'd1);
    check("single_wr_len", 64'(wr_burst_len), 64'd64);
    check("single_wr_addr", 64'(wr_burst_addr), 64'h100);
    check_grant("single_grant");
    ch_wr_burst_req[0] = 1'b0;
    beats = 0;
    for (int b = 0; b < 64; b++) begin
      wr_burst_data_req      = 1'b1;
      ch_wr_burst_data[0+:DW] = 64'hA5A5_0000_0000_0000 + 64'(b);
      #1;
      if (ch_wr_burst_data_req == 2'b01 && wr_burst_data == 64'hA5A5_0000_0000_0000 + 64'(b))
        beats++;
      @(negedge clk);
    end
    wr_burst_data_req = 1'b0;
    check("single_beats_routed", 64'(beats), 64'd64);
    wr_burst_finish = 1'b1;
    #1;
    check("single_fin_same_cycle", 64'(ch_wr_burst_finish), 64'b01);
    check("single_fin_no_rd", 64'(ch_rd_burst_finish), 64'd0);
    @(negedge clk);
    wr_burst_finish = 1'b0;
    #1;
    check("single_busy_after", 64'(busy), 64'd0);
    check("single_wr_req_drop", 64'(wr_burst_req), 64'd0);
    @(negedge clk);

    // Zero-length read on ch1 (slot 3)
    ch_rd_burst_req[1]      = 1'b1;
    ch_rd_burst_len[LW+:LW] = 10'd0;
    ch_rd_burst_addr[AW+:AW] = 24'h000300;
    exp_q.push_back(3);
    @(negedge clk);
    check("zl_busy", 64'(busy), 64'd1);
    check_grant("zl_grant");
    check("zl_no_rd_req", 64'(rd_burst_req), 64'd0);
    check("zl_no_fin_yet", 64'(ch_rd_burst_finish), 64'd0);
    @(negedge clk);
    check("zl_fin", 64'(ch_rd_burst_finish), 64'b10);
    check("zl_no_rd_req2", 64'(rd_burst_req), 64'd0);
    ch_rd_burst_req[1] = 1'b0;
    @(negedge clk);
    check("zl_fin_end", 64'(ch_rd_burst_finish), 64'd0);
    check("zl_idle", 64'(busy), 64'd0);

    // Isolation: ch1 read with stray write handshakes
    ch_rd_burst_req[1]       = 1'b1;
    ch_rd_burst_len[LW+:LW]  = 10'd8;
    ch_rd_burst_addr[AW+:AW] = 24'h000200;
    exp_q.push_back(3);
    @(negedge clk);
    check("iso_rd_req", 64'(rd_burst_req), 64'd1);
    check("iso_rd_len", 64'(rd_burst_len), 64'd8);
    check("iso_rd_addr", 64'(rd_burst_addr), 64'h200);
    check_grant("iso_grant");
    ch_rd_burst_req[1] = 1'b0;
    wr_burst_finish    = 1'b1;
    wr_burst_data_req  = 1'b1;
    #1;
    check("iso_stray_wr_fin", 64'(ch_wr_burst_finish), 64'd0);
    check("iso_stray_wr_dreq", 64'(ch_wr_burst_data_req), 64'd0);
    check("iso_stray_rd_fin", 64'(ch_rd_burst_finish), 64'd0);
    @(negedge clk);
    wr_burst_finish     = 1'b0;
    wr_burst_data_req   = 1'b0;
    check("iso_still_busy", 64'(busy), 64'd1);
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = 64'hDEAD_BEEF_0000_1234;
    #1;
    check("iso_valid_routed", 64'(ch_rd_burst_data_valid), 64'b10);
    check("iso_rd_data", ch_rd_burst_data, 64'hDEAD_BEEF_0000_1234);
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b1;
    #1;
    check("iso_rd_fin", 64'(ch_rd_burst_finish), 64'b10);
    check("iso_no_wr_fin", 64'(ch_wr_burst_finish), 64'd0);
    @(negedge clk);
    rd_burst_finish = 1'b0;
    check("iso_idle", 64'(busy), 64'd0);
    rd_burst_finish     = 1'b1;
    rd_burst_data_valid = 1'b1;
    wr_burst_finish     = 1'b1;
    #1;
    check("idle_stray_rd_fin", 64'(ch_rd_burst_finish), 64'd0);
    check("idle_stray_valid", 64'(ch_rd_burst_data_valid), 64'd0);
    check("idle_stray_wr_fin", 64'(ch_wr_burst_finish), 64'd0);
    @(negedge clk);
    clear_inputs();
    check("idle_stray_stays_idle", 64'(busy), 64'd0);

    // Contention: all four slots requesting from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < int'(CH); c++) begin
      ch_wr_burst_len[c*LW +: LW] = 10'd2;
      ch_rd_burst_len[c*LW +: LW] = 10'd2;
    end
    ch_wr_burst_req = '1;
    ch_rd_burst_req = '1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    for (int k = 0; k < 6; k++) begin
      wait_busy($sformatf("rr%0d_busy", k));
      e = (exp_q.size() != 0) ? exp_q[0] : 0;
      check_grant($sformatf("rr%0d_grant", k));
      if (e % 2 == 1) rd_burst_finish = 1'b1;
      else            wr_burst_finish = 1'b1;
      #1;
      if (e % 2 == 1) check($sformatf("rr%0d_fin", k), 64'(ch_rd_burst_finish), 64'd1 << (e / 2));
      else            check($sformatf("rr%0d_fin", k), 64'(ch_wr_burst_finish), 64'd1 << (e / 2));
      @(negedge clk);
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;
    end
    ch_wr_burst_req = '0;
    ch_rd_burst_req = '0;

    // Late release: ch0 write holds req one cycle past finish while ch1 write pends
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ch_wr_burst_len[0+:LW]  = 10'd4;
    ch_wr_burst_len[LW+:LW] = 10'd4;
    ch_wr_burst_req[0] = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    check_grant("lr_grant0");
    ch_wr_burst_req[1] = 1'b1;
    exp_q.push_back(2);
    @(negedge clk);
    wr_burst_finish = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0;
    @(negedge clk);
    ch_wr_burst_req[0] = 1'b0;
    ch_wr_burst_req[1] = 1'b0;
    check("lr_busy", 64'(busy), 64'd1);
    check_grant("lr_grant_ch1");
    wr_burst_finish = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0;
    check("lr_idle", 64'(busy), 64'd0);

    // Reset during beat 10 of a 32-beat ch0 read
    ch_rd_burst_req[0]     = 1'b1;
    ch_rd_burst_len[0+:LW] = 10'd32;
    exp_q.push_back(1);
    @(negedge clk);
    check_grant("mr_grant");
    ch_rd_burst_req[0] = 1'b0;
    for (int b = 1; b < 10; b++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = 64'(b);
      @(negedge clk);
    end
    rd_burst_data = 64'd10;
    #1;
    check("mr_beat10_valid", 64'(ch_rd_burst_data_valid), 64'b01);
    #1;
    rst = 1'b1;
    #1;
    check("mr_rd_req", 64'(rd_burst_req), 64'd0);
    check("mr_valid", 64'(ch_rd_burst_data_valid), 64'd0);
    check("mr_rd_data", ch_rd_burst_data, 64'd0);
    check("mr_fin", 64'(ch_rd_burst_finish), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_grant_slot", 64'(grant_slot), 64'd0);
    check("mr_rd_len", 64'(rd_burst_len), 64'd0);
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    ch_wr_burst_req     = 2'b11;
    exp_q.push_back(0);
    rst = 1'b0;
    @(negedge clk);
    check_grant("mr_first_grant");
    check("mr_wr_req", 64'(wr_burst_req), 64'd1);
    ch_wr_burst_req = '0;
    wr_burst_finish = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
